fp16_mul_sched: RTL

- Shares one bank of `LANES` FP16 multiplier wrappers (fixed latency `M_LAT`) among `NREQ` requesting SSM stages, e.g. xD and dA·h.
- Arbitrates one request per cycle and drives the multiplier operands and `valid_in`.
- Carries each request's requester ID and index tag (packed b/h/p) through a matched-latency shift pipeline, then returns results to the owning stage.
- Sits between the stage FSMs and the shared `fp16_mult_wrapper` array.

---
 rtl/fp16_mul_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fp16_mul_sched.sv
// fp16_mul_sched: round-robin scheduler sharing one FP16 multiplier bank among NREQ stages; define MUL_SCHED_BURST_EN for burst lock
module fp16_mul_sched #(
  parameter int NREQ = 2,
  parameter int LANES = 12,
  parameter int DW = 16,
  parameter int M_LAT = 6,
  parameter int TW = 30
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*LANES*DW-1:0] req_a_flat,
  input  logic [NREQ*LANES*DW-1:0] req_b_flat,
  input  logic [NREQ*LANES-1:0]    req_mask,
  input  logic [NREQ*TW-1:0]       req_tag,
  output logic [LANES*DW-1:0]      mul_a_flat,
  output logic [LANES*DW-1:0]      mul_b_flat,
  output logic                     mul_valid_in,
  input  logic [LANES*DW-1:0]      mul_result_flat,
  input  logic                     mul_valid_out,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [LANES*DW-1:0]      rsp_data_flat,
  output logic [LANES-1:0]         rsp_mask,
  output logic [TW-1:0]            rsp_tag,
  output logic                     idle,
  output logic                     err_lat
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [IW-1:0] rr, gid, iss_id;
  logic gnt;
  logic [LANES*DW-1:0] op_a, op_b, res_m;
  logic [LANES-1:0] sel_mask, iss_mask;
  logic [TW-1:0] sel_tag, iss_tag;
  logic [M_LAT-1:0] pv;
  logic [IW-1:0] pid [M_LAT];
  logic [LANES-1:0] pmask [M_LAT];
  logic [TW-1:0] ptag [M_LAT];
`ifdef MUL_SCHED_BURST_EN
  logic lock;
  logic [IW-1:0] lock_id;
`else
  logic unused_last;
  assign unused_last = ^req_last;
`endif
  // grant the first valid requester at or after rr; a held burst lock overrides the search
  always_comb begin
    gnt = 1'b0;
    gid = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_valid[(int'(rr) + i) % NREQ]) begin
        gnt = 1'b1;
        gid = IW'((int'(rr) + i) % NREQ);
      end
`ifdef MUL_SCHED_BURST_EN
    if (lock) begin
      gnt = req_valid[lock_id];
      gid = lock_id;
    end
`endif
    if (!rst_n) gnt = 1'b0;
    req_ready = gnt ? NREQ'(1) << gid : '0;
  end
  assign sel_mask = req_mask[int'(gid) * LANES +: LANES];
  assign sel_tag = req_tag[int'(gid) * TW +: TW];
  // select the granted requester's operands, zeroing masked lanes
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int l = 0; l < LANES; l++) begin
      op_a[l*DW +: DW] = sel_mask[l] ? req_a_flat[(int'(gid) * LANES + l) * DW +: DW] : '0;
      op_b[l*DW +: DW] = sel_mask[l] ? req_b_flat[(int'(gid) * LANES + l) * DW +: DW] : '0;
    end
  end
  // issue register, round-robin pointer and burst lock
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr <= '0;
      mul_valid_in <= 1'b0;
      mul_a_flat <= '0;
      mul_b_flat <= '0;
      iss_id <= '0;
      iss_mask <= '0;
      iss_tag <= '0;
`ifdef MUL_SCHED_BURST_EN
      lock <= 1'b0;
      lock_id <= '0;
`endif
    end else begin
      mul_valid_in <= gnt;
      if (gnt) begin
        rr <= gid == IW'(NREQ - 1) ? '0 : gid + IW'(1);
        mul_a_flat <= op_a;
        mul_b_flat <= op_b;
        iss_id <= gid;
        iss_mask <= sel_mask;
        iss_tag <= sel_tag;
`ifdef MUL_SCHED_BURST_EN
        lock <= !req_last[gid];
        lock_id <= gid;
`endif
      end
    end
  end
  // pipe valids track the multiplier latency and are dropped on reset
  always_ff @(posedge clk) begin
    if (!rst_n) pv <= '0;
    else begin
      pv[0] <= mul_valid_in;
      for (int k = 1; k < M_LAT; k++) pv[k] <= pv[k-1];
    end
  end
  // pipe payload needs no reset since it is only consumed alongside a valid
  always_ff @(posedge clk) begin
    pid[0] <= iss_id;
    pmask[0] <= iss_mask;
    ptag[0] <= iss_tag;
    for (int k = 1; k < M_LAT; k++) begin
      pid[k] <= pid[k-1];
      pmask[k] <= pmask[k-1];
      ptag[k] <= ptag[k-1];
    end
  end
  // force masked result lanes to zero
  always_comb begin
    res_m = '0;
    for (int l = 0; l < LANES; l++) res_m[l*DW +: DW] = pmask[M_LAT-1][l] ? mul_result_flat[l*DW +: DW] : '0;
  end
  // return stage routes the result to its owner and flags latency mismatches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data_flat <= '0;
      rsp_mask <= '0;
      rsp_tag <= '0;
      err_lat <= 1'b0;
    end else begin
      err_lat <= err_lat | (pv[M_LAT-1] != mul_valid_out);
      rsp_valid <= pv[M_LAT-1] ? NREQ'(1) << pid[M_LAT-1] : '0;
      if (pv[M_LAT-1]) begin
        rsp_data_flat <= res_m;
        rsp_mask <= pmask[M_LAT-1];
        rsp_tag <= ptag[M_LAT-1];
      end
    end
  end
  assign idle = !(mul_valid_in || |pv);
endmodule
